// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS2 key decoder: FSM states, prefix and
// response bytes, joystick key codes and the keys bitmap layout.
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_ev_t;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ECHO   = 8'hEE;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERR0   = 8'h00;
  localparam logic [7:0] RSP_ERR1   = 8'hFF;

  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_FIRE1 = 8'h14;
  localparam logic [7:0] K_FIRE2 = 8'h29;
  localparam logic [7:0] K_START = 8'h5A;
  localparam logic [7:0] K_ESC   = 8'h76;

  localparam int KB_UP    = 0;
  localparam int KB_DOWN  = 1;
  localparam int KB_LEFT  = 2;
  localparam int KB_RIGHT = 3;
  localparam int KB_FIRE1 = 4;
  localparam int KB_FIRE2 = 5;
  localparam int KB_START = 6;
  localparam int KB_ESC   = 7;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_resp(input logic [7:0] c);
    return (c == RSP_ACK) || (c == RSP_BAT) || (c == RSP_ECHO) ||
           (c == RSP_RESEND) || (c == RSP_ERR0) || (c == RSP_ERR1);
  endfunction

  // One-hot bitmap position for a key event; zero when the key is unmapped.
  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] c);
    logic [7:0] m;
    m = '0;
    if (ext && c == K_UP)     m[KB_UP]    = 1'b1;
    if (ext && c == K_DOWN)   m[KB_DOWN]  = 1'b1;
    if (ext && c == K_LEFT)   m[KB_LEFT]  = 1'b1;
    if (ext && c == K_RIGHT)  m[KB_RIGHT] = 1'b1;
    if (c == K_FIRE1)         m[KB_FIRE1] = 1'b1;
    if (!ext && c == K_FIRE2) m[KB_FIRE2] = 1'b1;
    if (!ext && c == K_START) m[KB_START] = 1'b1;
    if (!ext && c == K_ESC)   m[KB_ESC]   = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; pointers carry a wrap bit so full/empty need no counter.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             not_empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;

  assign not_empty = ~empty;
  assign dout      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the PS2 byte stream into make/break key events: prefix FSM, joystick
// bitmap and an event FIFO for the menu logic.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic [7:0] keys,
  output logic       overflow
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t      state, state_nxt;
  logic [2:0]  skip, skip_nxt;
  logic        valid_q, stb;
  logic [7:0]  code_q;
  logic [CW-1:0] cnt;
  logic        timeout, emit, dropped;
  key_ev_t     ev;
  logic [7:0]  mask;

  // Strobe is registered so the FSM sees a clean one-cycle pulse per byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      stb     <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid;
      stb     <= valid & ~valid_q;
      if (valid & ~valid_q) code_q <= code;
    end
  end

  assign timeout = (state != IDLE) && !stb && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || stb || timeout) cnt <= '0;
    else                                        cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    emit      = 1'b0;
    ev        = '{brk: 1'b0, ext: 1'b0, code: code_q};
    if (timeout) begin
      state_nxt = IDLE;
    end else if (stb) begin
      case (state)
        IDLE: begin
          if (code_q == PFX_EXT)        state_nxt = EXT;
          else if (code_q == PFX_BRK)   state_nxt = BRK;
          else if (code_q == PFX_PAUSE) begin
            state_nxt = PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else if (!is_resp(code_q)) emit = 1'b1;
        end
        EXT: begin
          state_nxt = IDLE;
          if (code_q == PFX_BRK) state_nxt = EXT_BRK;
          else if (code_q != PFX_EXT && code_q != PFX_PAUSE && code_q != FAKE_SHIFT) begin
            emit   = 1'b1;
            ev.ext = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          emit      = 1'b1;
          ev.brk    = 1'b1;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (code_q != FAKE_SHIFT) begin
            emit   = 1'b1;
            ev.brk = 1'b1;
            ev.ext = 1'b1;
          end
        end
        PAUSE: begin
          // Pause is an 8-byte blob with no break; report it once as a marker.
          if (skip == 3'd1) begin
            state_nxt = IDLE;
            emit      = 1'b1;
            ev.ext    = 1'b1;
            ev.code   = PFX_PAUSE;
          end else begin
            skip_nxt = skip - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mask = key_mask(ev.ext, ev.code);

  always_ff @(posedge clk) begin
    if (rst) begin
      keys     <= '0;
      overflow <= 1'b0;
    end else begin
      if (emit) keys <= ev.brk ? (keys & ~mask) : (keys | mask);
      if (dropped) overflow <= 1'b1;
    end
  end

  ps2_event_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (emit),
    .din       (ev),
    .pop       (ev_ready),
    .dout      (ev_data),
    .not_empty (ev_valid),
    .dropped   (dropped)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; expected events go into a queue as bytes
// are sent and are popped when the FIFO presents them.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code;
  logic       valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;
  logic [7:0] keys;
  logic       overflow;

  int errors = 0;
  int total  = 0;
  logic [9:0] exp_q [$];

  ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(200)) dut (
    .clk      (clk),
    .rst      (rst),
    .code     (code),
    .valid    (valid),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .keys     (keys),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code  = b;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (!ev_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_ev"}, 32'(ev_data), 32'(e));
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
    chk({tag, "_empty"}, 32'(ev_valid), 32'(0));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; code = '0; ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_keys", 32'(keys), 32'(0));
    chk("rst_evv", 32'(ev_valid), 32'(0));
    chk("rst_evd", 32'(ev_data), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));

    // long valid pulse: one event, two-edge latency
    code = 8'h1C; valid = 1'b1;
    @(negedge clk);
    chk("lat1_evv", 32'(ev_valid), 32'(0));
    @(negedge clk);
    chk("lat2_evv", 32'(ev_valid), 32'(1));
    exp_q.push_back(10'h01C);
    repeat (15) @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_keys", 32'(keys), 32'(0));
    drain("t1");

    send(8'hFA);
    drain("resp");

    send(8'hE0); send(8'h75);
    exp_q.push_back(10'h175);
    chk("t2_up_make", 32'(keys), 32'(8'h01));
    drain("t2a");
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(10'h375);
    chk("t2_up_brk", 32'(keys), 32'(8'h00));
    drain("t2b");

    send(8'hE0); send(8'h12);
    drain("fake_shift");

    // prefix abandoned after the timeout window
    send(8'hE0);
    repeat (250) @(negedge clk);
    send(8'h29);
    exp_q.push_back(10'h029);
    chk("t3_keys", 32'(keys), 32'(8'h20));
    drain("t3a");
    // prefix still live inside the window
    send(8'hE0);
    repeat (150) @(negedge clk);
    send(8'h75);
    exp_q.push_back(10'h175);
    chk("t3_keys_b", 32'(keys), 32'(8'h21));
    drain("t3b");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    exp_q.push_back(10'h1E1);
    chk("t4_keys", 32'(keys), 32'(8'h21));
    drain("t4");

    do_reset();
    send(8'h1C); send(8'h14); send(8'h29); send(8'h76);
    exp_q.push_back(10'h01C); exp_q.push_back(10'h014);
    exp_q.push_back(10'h029); exp_q.push_back(10'h076);
    chk("t5_keys", 32'(keys), 32'(8'hB0));
    chk("t5_ovf_full", 32'(overflow), 32'(0));
    // pop lands on the same edge as the push into a full FIFO
    @(negedge clk);
    code = 8'h1B; valid = 1'b1;
    @(negedge clk);
    chk("t5_head", 32'(ev_data), 32'(exp_q.pop_front()));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0; valid = 1'b0;
    exp_q.push_back(10'h01B);
    repeat (3) @(negedge clk);
    chk("t5_ovf_popush", 32'(overflow), 32'(0));
    send(8'h5A);
    chk("t5_ovf_drop", 32'(overflow), 32'(1));
    chk("t5_keys_drop", 32'(keys), 32'(8'hF0));
    drain("t5");
    chk("t5_ovf_sticky", 32'(overflow), 32'(1));

    send(8'hE0); send(8'hF0);
    do_reset();
    chk("t6_keys", 32'(keys), 32'(0));
    chk("t6_evv", 32'(ev_valid), 32'(0));
    chk("t6_ovf", 32'(overflow), 32'(0));
    send(8'h5A);
    exp_q.push_back(10'h05A);
    chk("t6_start", 32'(keys), 32'(8'h40));
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
